fetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline. It produces the INS word that the control unit decodes and consumes that unit's pcSrc, pcWrite, ifidWrite, ifidFlush and jORb outputs.
- Owns the PC, the IF/ID pipeline register, and a variable-latency instruction-memory request/ready handshake.
- Computes jump and branch targets from its own IF/ID contents, and discards in-flight fetches on redirect.

---
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IF/ID register and a variable-latency
// imem request/ready handshake with redirect and fetch discard.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pcSrc,
   input  logic        jORb,
   input  logic        pcWrite,
   input  logic        ifidWrite,
   input  logic        ifidFlush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ifid_ins,
   output logic [31:0] ifid_pc4,
   output logic        ifid_valid,
   output logic [15:0] kill_count
);

   typedef enum logic [1:0] {
      START,
      REQ,
      HOLD,
      KILL
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] buffer;
   logic [31:0] redirect_pc;

   logic [31:0] jump_tgt;
   logic [31:0] branch_tgt;
   logic [31:0] target;
   logic [31:0] pc4_next;
   logic [31:0] fetch_word;
   logic [15:0] kill_inc;
   logic        adv;
   logic        fetch_load;

   assign imem_addr = pc;

   always_comb begin
      jump_tgt   = {ifid_pc4[31:28], ifid_ins[25:0], 2'b00};
      branch_tgt = ifid_pc4
                 + {{14{ifid_ins[15]}}, ifid_ins[15:0], 2'b00};
      target     = jORb ? branch_tgt : jump_tgt;
      pc4_next   = pc + 32'd4;
      adv        = pcWrite & ifidWrite;
      kill_inc   = (kill_count == 16'hFFFF) ? kill_count
                                             : kill_count + 16'd1;
      // A word reaches IF/ID from memory directly or from the buffer
      fetch_load = !pcSrc && adv &&
                   ((state == REQ && imem_ready) || state == HOLD);
      fetch_word = (state == HOLD) ? buffer : imem_rdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= START;
         pc          <= RESET_PC;
         buffer      <= 32'h0;
         redirect_pc <= 32'h0;
         imem_req    <= 1'b0;
         kill_count  <= 16'h0;
         ifid_ins    <= NOP;
         ifid_pc4    <= 32'h0;
         ifid_valid  <= 1'b0;
      end else begin
         unique case (state)
            START: begin
               state    <= REQ;
               imem_req <= 1'b1;
            end
            REQ: begin
               if (pcSrc && imem_ready) begin
                  pc         <= target;
                  kill_count <= kill_inc;
               end else if (pcSrc) begin
                  redirect_pc <= target;
                  state       <= KILL;
               end else if (imem_ready && adv) begin
                  pc <= pc4_next;
               end else if (imem_ready) begin
                  buffer   <= imem_rdata;
                  state    <= HOLD;
                  imem_req <= 1'b0;
               end
            end
            HOLD: begin
               if (pcSrc) begin
                  pc         <= target;
                  kill_count <= kill_inc;
                  state      <= REQ;
                  imem_req   <= 1'b1;
               end else if (adv) begin
                  pc       <= pc4_next;
                  state    <= REQ;
                  imem_req <= 1'b1;
               end
            end
            KILL: begin
               // Address stays put until the old request completes
               if (imem_ready) begin
                  pc         <= pcSrc ? target : redirect_pc;
                  kill_count <= kill_inc;
                  state      <= REQ;
               end else if (pcSrc) begin
                  redirect_pc <= target;
               end
            end
            default: begin
               state    <= START;
               imem_req <= 1'b0;
            end
         endcase

         if (pcSrc || ifidFlush) begin
            ifid_ins   <= NOP;
            ifid_valid <= 1'b0;
         end else if (fetch_load) begin
            ifid_ins   <= fetch_word;
            ifid_pc4   <= pc4_next;
            ifid_valid <= 1'b1;
         end else if (ifidWrite) begin
            ifid_ins   <= NOP;
            ifid_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        pcSrc, jORb, pcWrite, ifidWrite, ifidFlush;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] ifid_ins;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;
   logic [15:0] kill_count;

   int n_checks = 0;
   int n_errors = 0;
   bit rnd_mem  = 1'b0;

   fetch_unit dut (
      .clk        (clk),
      .rst        (rst),
      .pcSrc      (pcSrc),
      .jORb       (jORb),
      .pcWrite    (pcWrite),
      .ifidWrite  (ifidWrite),
      .ifidFlush  (ifidFlush),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .ifid_ins   (ifid_ins),
      .ifid_pc4   (ifid_pc4),
      .ifid_valid (ifid_valid),
      .kill_count (kill_count)
   );

   always #5 clk = ~clk;

   // model state
   bit          m_started, m_killp, m_bufv, m_valid;
   logic [31:0] m_pc, m_buf, m_redir, m_ins, m_pc4;
   logic [15:0] m_kill;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h @%0t", tag, got, exp,
                  $time);
      end
   endtask

   function automatic logic [31:0] memw(input logic [31:0] a);
      if (rnd_mem) return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
      if (a == 32'h40) return 32'h1000_FFFE;
      if (a == 32'h3C) return 32'h0800_0100;
      return a;
   endfunction

   task automatic model_reset();
      m_started = 0; m_killp = 0; m_bufv = 0; m_valid = 0;
      m_pc = 0; m_buf = 0; m_redir = 0; m_ins = 0; m_pc4 = 0;
      m_kill = 0;
   endtask

   function automatic logic m_req();
      return m_started && !m_bufv;
   endfunction

   task automatic bump();
      if (m_kill != 16'hFFFF) m_kill = m_kill + 16'd1;
   endtask

   task automatic model_step();
      logic [31:0] tgt, word;
      logic got;
      logic adv;
      if (jORb) tgt = m_pc4 + 32'($signed(m_ins[15:0])) * 4;
      else      tgt = {m_pc4[31:28], m_ins[25:0], 2'b00};
      adv  = pcWrite && ifidWrite;
      got  = 0;
      word = 0;
      if (!m_started) begin
         m_started = 1;
      end else if (m_killp) begin
         if (imem_ready) begin
            m_pc = pcSrc ? tgt : m_redir;
            bump();
            m_killp = 0;
         end else if (pcSrc) m_redir = tgt;
      end else if (m_bufv) begin
         if (pcSrc) begin
            m_pc = tgt; bump(); m_bufv = 0;
         end else if (adv) begin
            word = m_buf; got = 1; m_bufv = 0;
         end
      end else if (pcSrc) begin
         if (imem_ready) begin
            m_pc = tgt; bump();
         end else begin
            m_redir = tgt; m_killp = 1;
         end
      end else if (imem_ready) begin
         if (adv) begin
            word = imem_rdata; got = 1;
         end else begin
            m_buf = imem_rdata; m_bufv = 1;
         end
      end
      if (pcSrc || ifidFlush) begin
         m_ins = 32'h0; m_valid = 0;
      end else if (got) begin
         m_ins = word; m_pc4 = m_pc + 4; m_valid = 1;
      end else if (ifidWrite) begin
         m_ins = 32'h0; m_valid = 0;
      end
      if (got) m_pc = m_pc + 4;
   endtask

   task automatic step(input logic s, input logic j, input logic pw,
                       input logic iw, input logic fl, input logic rd);
      pcSrc      = s;
      jORb       = j;
      pcWrite    = pw;
      ifidWrite  = iw;
      ifidFlush  = fl;
      imem_ready = rd && m_req();
      imem_rdata = memw(m_pc);
      model_step();
      @(posedge clk);
      #1;
      chk("req",   32'(imem_req),   32'(m_req()));
      chk("addr",  imem_addr,       m_pc);
      chk("ins",   ifid_ins,        m_ins);
      chk("pc4",   ifid_pc4,        m_pc4);
      chk("valid", 32'(ifid_valid), 32'(m_valid));
      chk("kill",  32'(kill_count), 32'(m_kill));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req"},   32'(imem_req),   32'h0);
      chk({tag, "_addr"},  imem_addr,       32'h0);
      chk({tag, "_ins"},   ifid_ins,        32'h0);
      chk({tag, "_pc4"},   ifid_pc4,        32'h0);
      chk({tag, "_valid"}, 32'(ifid_valid), 32'h0);
      chk({tag, "_kill"},  32'(kill_count), 32'h0);
   endtask

   initial begin
      rst = 1'b0;
      pcSrc = 0; jORb = 0; pcWrite = 1; ifidWrite = 1;
      ifidFlush = 0; imem_ready = 0; imem_rdata = 0;
      model_reset();
      #1;
      check_reset_outputs("rst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("start_req", 32'(imem_req), 32'h0);

      // streaming, ready tied high, rdata = addr
      step(0, 0, 1, 1, 0, 1);
      chk("first_addr", imem_addr, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         step(0, 0, 1, 1, 0, 1);
         chk("stream_addr", imem_addr, 32'(4 * k));
         chk("stream_pc4", ifid_pc4, 32'(4 * k));
         chk("stream_ins", ifid_ins, 32'(4 * (k - 1)));
         chk("stream_valid", 32'(ifid_valid), 32'h1);
      end

      // run until the BEQ at 0x40 sits in IF/ID
      for (int k = 0; k < 40 && m_pc4 != 32'h44; k++)
         step(0, 0, 1, 1, 0, 1);
      chk("beq_pc4", ifid_pc4, 32'h44);
      chk("beq_ins", ifid_ins, 32'h1000_FFFE);
      step(1, 1, 1, 1, 0, 0);
      chk("kill_hold_addr", imem_addr, 32'h44);
      step(0, 0, 1, 1, 0, 0);
      chk("kill_hold_addr2", imem_addr, 32'h44);
      step(0, 0, 1, 1, 0, 1);
      chk("beq_target", imem_addr, 32'h3C);
      chk("beq_kill", 32'(kill_count), 32'h1);
      chk("beq_valid", 32'(ifid_valid), 32'h0);

      // J 0x100 fetched from 0x3C, then redirect with ready high
      step(0, 0, 1, 1, 0, 1);
      step(1, 0, 1, 1, 0, 1);
      chk("j_target", imem_addr, 32'h400);
      chk("j_nop", ifid_ins, 32'h0);
      chk("j_kill", 32'(kill_count), 32'h2);

      // stall while the word at 0x400 returns
      step(0, 0, 0, 0, 0, 1);
      chk("hold_req", 32'(imem_req), 32'h0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 1, 1, 0, 0);
      chk("hold_ins", ifid_ins, memw(32'h400));
      chk("hold_pc4", ifid_pc4, 32'h404);
      chk("hold_next", imem_addr, 32'h404);

      // async reset while in KILL
      step(1, 1, 1, 1, 0, 0);
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("async");
      model_reset();
      @(negedge clk);
      rst = 1'b1;

      // kill_count saturation
      step(0, 0, 1, 1, 0, 1);
      #1;
      force dut.kill_count = 16'hFFFE;
      #1;
      release dut.kill_count;
      m_kill = 16'hFFFE;
      for (int k = 0; k < 3; k++)
         step(1, 1, 1, 1, 0, 1);
      chk("kill_sat", 32'(kill_count), 32'hFFFF);

      // random traffic
      rnd_mem = 1'b1;
      for (int k = 0; k < 2000; k++)
         step($urandom_range(0, 7) == 0, 1'($urandom),
              $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
